// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared types and constants for the 20-bit CPU control path
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Instruction field positions
    localparam int OP_MSB   = 19;
    localparam int OP_LSB   = 14;
    localparam int RS1_MSB  = 13;
    localparam int RS1_LSB  = 11;
    localparam int RS2_MSB  = 10;
    localparam int RS2_LSB  = 8;
    localparam int RD_MSB   = 7;
    localparam int RD_LSB   = 5;
    localparam int MODE_MSB = 1;
    localparam int MODE_LSB = 0;

    localparam logic [5:0] OP_TRAP = 6'd0;
    localparam logic [5:0] OP_JZ   = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd9;
    localparam logic [5:0] OP_GT   = 6'd24;

    localparam logic [5:0] CF_LO  = 6'd1;
    localparam logic [5:0] CF_HI  = 6'd7;
    localparam logic [5:0] ALU_LO = 6'd8;
    localparam logic [5:0] ALU_HI = 6'd47;
    localparam logic [5:0] LD_LO  = 6'd48;
    localparam logic [5:0] LD_HI  = 6'd55;
    localparam logic [5:0] ST_LO  = 6'd56;
    localparam logic [5:0] ST_HI  = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    // Only six general registers exist; encodings 6 and 7 are illegal
    function automatic logic reg_invalid(input logic [2:0] r);
        return r[2] & r[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_classifier.sv
// ============================================================================
// opcode_classifier : combinational opcode -> class / operand-usage decode
// Rev 1.0
// ============================================================================
`default_nettype none

module opcode_classifier
    import cpu_pkg::*;
(
    input  logic [5:0] op_i,
    output logic       is_trap_o,
    output logic       has_wb_o,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       uses_rd_o
);

    logic is_cf;
    logic is_alu;
    logic is_ld;
    logic is_st;

    // Named opcodes listed explicitly so they stay visible in the decode
    assign is_cf  = ((op_i >= CF_LO)  && (op_i <= CF_HI))  || (op_i == OP_JZ);
    assign is_alu = ((op_i >= ALU_LO) && (op_i <= ALU_HI)) || (op_i == OP_AND) || (op_i == OP_GT);
    assign is_ld  = (op_i >= LD_LO) && (op_i <= LD_HI);
    assign is_st  = (op_i >= ST_LO) && (op_i <= ST_HI);

    assign is_trap_o  = (op_i == OP_TRAP);
    assign has_wb_o   = is_alu | is_ld;
    assign uses_rs1_o = is_cf | is_alu | is_ld | is_st;
    assign uses_rs2_o = is_alu | is_st;
    assign uses_rd_o  = is_alu | is_ld;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : FETCH/DECODE/EXECUTE/WRITEBACK sequencer with TRAP handling.
// Optional macro TRAP_ON_FAULT_EN: datapath faults in EXECUTE enter TRAP.
// Rev 1.0
// ============================================================================
`default_nettype none

module control_unit
    import cpu_pkg::*;
#(
    parameter int IW   = 20,
    parameter int NREG = 6,
    parameter int OPW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instruction,
    input  logic          zero_flag,
    input  logic          sign_flag,
    input  logic          overflow_flag,
    input  logic          underflow_flag,
    input  logic          carry_flag_fw,
    input  logic          carry_flag_hwl,
    input  logic          carry_flag_hwh,
    input  logic          div_by_zero_flag,
    input  logic          half_word_mode,
    input  logic          same_reg_flag,
    input  logic          mem_violation_flag,
    input  logic          mem_corruption_flag,
    input  logic          trap_mode_flag,
    input  logic [IW-1:0] registers [NREG-1:0],
    output logic          fetch_enable,
    output logic          decode_enable,
    output logic          execute_enable,
    output logic          write_back_enable
);

    state_e        state_q;
    logic [IW-1:0] ir_q;

    logic [OPW-1:0] op;
    logic           is_trap;
    logic           has_wb;
    logic           uses_rs1;
    logic           uses_rs2;
    logic           uses_rd;
    logic           decode_trap;
    logic           fault_trap;

    assign op = ir_q[OP_MSB:OP_LSB];

    opcode_classifier u_classifier (
        .op_i       (op),
        .is_trap_o  (is_trap),
        .has_wb_o   (has_wb),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .uses_rd_o  (uses_rd)
    );

    assign decode_trap = is_trap
                       | (uses_rs1 & reg_invalid(ir_q[RS1_MSB:RS1_LSB]))
                       | (uses_rs2 & reg_invalid(ir_q[RS2_MSB:RS2_LSB]))
                       | (uses_rd  & reg_invalid(ir_q[RD_MSB:RD_LSB]));

`ifdef TRAP_ON_FAULT_EN
    assign fault_trap = div_by_zero_flag | mem_violation_flag | mem_corruption_flag;
`else
    assign fault_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE:      state_q <= ST_FETCH;
                ST_FETCH: begin
                    ir_q    <= instruction;
                    state_q <= ST_DECODE;
                end
                ST_DECODE:    state_q <= decode_trap ? ST_TRAP : ST_EXECUTE;
                ST_EXECUTE: begin
                    if (fault_trap)  state_q <= ST_TRAP;
                    else if (has_wb) state_q <= ST_WRITEBACK;
                    else             state_q <= ST_FETCH;
                end
                ST_WRITEBACK: state_q <= ST_FETCH;
                ST_TRAP:      state_q <= ST_FETCH;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated with reset so the enables are quiet for the whole reset window
    assign fetch_enable      = reset & (state_q == ST_FETCH);
    assign decode_enable     = reset & (state_q == ST_DECODE);
    assign execute_enable    = reset & (state_q == ST_EXECUTE);
    assign write_back_enable = reset & (state_q == ST_WRITEBACK);

    // Datapath-only inputs: carried through a reduction so they stay connected
    logic [IW-1:0] reg_fold;
    always_comb begin
        reg_fold = '0;
        for (int i = 0; i < NREG; i++) reg_fold = reg_fold ^ registers[i];
    end

    logic unused_inputs;
    assign unused_inputs = ^{reg_fold, ir_q[RD_LSB-1:MODE_LSB], zero_flag, sign_flag,
                             overflow_flag, underflow_flag, carry_flag_fw, carry_flag_hwl,
                             carry_flag_hwh, half_word_mode, same_reg_flag, trap_mode_flag,
                             div_by_zero_flag, mem_violation_flag, mem_corruption_flag};

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : table-driven, scoreboarded check of the control_unit sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] instruction;
    logic        zero_flag, sign_flag, overflow_flag, underflow_flag;
    logic        carry_flag_fw, carry_flag_hwl, carry_flag_hwh;
    logic        div_by_zero_flag, half_word_mode, same_reg_flag;
    logic        mem_violation_flag, mem_corruption_flag, trap_mode_flag;
    logic [19:0] registers [5:0];
    logic        fetch_enable, decode_enable, execute_enable, write_back_enable;

    always #5 clk = ~clk;

    control_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction         (instruction),
        .zero_flag           (zero_flag),
        .sign_flag           (sign_flag),
        .overflow_flag       (overflow_flag),
        .underflow_flag      (underflow_flag),
        .carry_flag_fw       (carry_flag_fw),
        .carry_flag_hwl      (carry_flag_hwl),
        .carry_flag_hwh      (carry_flag_hwh),
        .div_by_zero_flag    (div_by_zero_flag),
        .half_word_mode      (half_word_mode),
        .same_reg_flag       (same_reg_flag),
        .mem_violation_flag  (mem_violation_flag),
        .mem_corruption_flag (mem_corruption_flag),
        .trap_mode_flag      (trap_mode_flag),
        .registers           (registers),
        .fetch_enable        (fetch_enable),
        .decode_enable       (decode_enable),
        .execute_enable      (execute_enable),
        .write_back_enable   (write_back_enable)
    );

    wire [3:0] en = {fetch_enable, decode_enable, execute_enable, write_back_enable};

    typedef enum int {K_WB, K_NOWB, K_TRAP, K_FAULT} kind_e;
    typedef struct {
        logic [19:0] instr;
        logic        zf;
        logic        hw;
        logic        dz;
        logic        mv;
        logic        mc;
        kind_e       kind;
    } vec_t;

`ifdef TRAP_ON_FAULT_EN
    localparam kind_e FK = K_FAULT;
`else
    localparam kind_e FK = K_WB;
`endif

    localparam int NV = 16;
    vec_t       vecs [NV];
    logic [3:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: enables got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_seq(input kind_e k);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        case (k)
            K_WB:    begin exp_q.push_back(4'b0010); exp_q.push_back(4'b0001); end
            K_NOWB:  exp_q.push_back(4'b0010);
            K_TRAP:  exp_q.push_back(4'b0000);
            K_FAULT: begin exp_q.push_back(4'b0010); exp_q.push_back(4'b0000); end
            default: ;
        endcase
    endtask

    // Entered at a negedge while the DUT is in FETCH; leaves at the next FETCH
    task automatic run_vec(input int i);
        logic [3:0] e;
        instruction         = vecs[i].instr;
        zero_flag           = vecs[i].zf;
        half_word_mode      = vecs[i].hw;
        sign_flag           = vecs[i].zf ^ vecs[i].hw;
        div_by_zero_flag    = vecs[i].dz;
        mem_violation_flag  = vecs[i].mv;
        mem_corruption_flag = vecs[i].mc;
        push_seq(vecs[i].kind);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i), en, e);
            @(negedge clk);
        end
        div_by_zero_flag    = 1'b0;
        mem_violation_flag  = 1'b0;
        mem_corruption_flag = 1'b0;
    endtask

    initial begin
        //            instr                                        zf    hw    dz    mv    mc    kind
        vecs[0]  = '{20'b00100110010100000010,                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_WB};
        vecs[1]  = '{20'b01100001110001000010,                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, K_WB};
        vecs[2]  = '{20'h00000,                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_TRAP};
        vecs[3]  = '{20'b00001100100000000000,                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_NOWB};
        vecs[4]  = '{20'b00001100100000000000,                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, K_NOWB};
        vecs[5]  = '{20'b00100110010100000010,                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FK};
        vecs[6]  = '{{6'd9,  3'd6, 3'd1, 3'd2, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_TRAP};
        vecs[7]  = '{{6'd8,  3'd1, 3'd2, 3'd7, 3'd0, 2'b00},       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K_TRAP};
        vecs[8]  = '{{6'd1,  3'd7, 3'd0, 3'd0, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_TRAP};
        vecs[9]  = '{{6'd7,  3'd0, 3'd7, 3'd6, 3'd0, 2'b10},       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, K_NOWB};
        vecs[10] = '{{6'd47, 3'd5, 3'd5, 3'd5, 3'd0, 2'b01},       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K_WB};
        vecs[11] = '{{6'd48, 3'd2, 3'd0, 3'd3, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_WB};
        vecs[12] = '{{6'd55, 3'd1, 3'd7, 3'd4, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FK};
        vecs[13] = '{{6'd56, 3'd1, 3'd2, 3'd7, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_NOWB};
        vecs[14] = '{{6'd63, 3'd3, 3'd6, 3'd0, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_TRAP};
        vecs[15] = '{{6'd24, 3'd0, 3'd1, 3'd2, 3'd0, 2'b10},       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FK};

        reset = 1'b0;
        instruction = '0;
        {zero_flag, sign_flag, overflow_flag, underflow_flag} = '0;
        {carry_flag_fw, carry_flag_hwl, carry_flag_hwh} = '0;
        {div_by_zero_flag, half_word_mode, same_reg_flag} = '0;
        {mem_violation_flag, mem_corruption_flag, trap_mode_flag} = '0;
        for (int r = 0; r < 6; r++) registers[r] = 20'($urandom);

        #1 check("reset_t0", en, 4'b0000);
        @(negedge clk) check("reset_c1", en, 4'b0000);
        @(negedge clk) check("reset_c2", en, 4'b0000);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset asserted mid-instruction during DECODE
        instruction = 20'b00100110010100000010;
        check("midrst_fetch", en, 4'b1000);
        @(negedge clk) check("midrst_decode", en, 4'b0100);
        reset = 1'b0;
        #1 check("midrst_gated", en, 4'b0000);
        @(negedge clk) check("midrst_idle", en, 4'b0000);
        reset = 1'b1;
        @(negedge clk) check("midrst_refetch", en, 4'b1000);
        run_vec(1);
        check("final_fetch", en, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
